pc_flow_ctrl: RTL and testbench

//  Sequences the PC register: merges redirect and stall requests into one jump/hold command per cycle.

---
 rtl/pc_flow_ctrl.sv | 179 +++++++++++++++++
 tb/tb_pc_flow_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pc_flow_ctrl.sv
// Purpose: merges EX/interrupt redirects and hold sources into one PC jump/hold command per cycle.
// Latency: redirects issue combinationally in the request cycle; halted_o and pc_reset_o are registered.
// Backpressure: bus_hold_i parks one redirect in a pending slot until the fetch port is granted again.
module pc_flow_ctrl #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned FLUSH_CYCLES = 2   // legal range 1..7, fits the 3-bit flush counter
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ex_jump_i,
  input  logic [ADDR_W-1:0] ex_jump_addr_i,
  input  logic              int_jump_i,
  input  logic [ADDR_W-1:0] int_jump_addr_i,
  input  logic              ex_hold_i,
  input  logic              bus_hold_i,
  input  logic              jtag_halt_i,
  input  logic              jtag_reset_i,
  output logic              jump_flag_o,
  output logic [ADDR_W-1:0] jump_addr_o,
  output logic [1:0]        hold_flag_o,
  output logic              flush_o,
  output logic              pc_reset_o,
  output logic              halted_o
);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_HALT_WAIT = 2'd1,
    ST_HALTED    = 2'd2
  } state_e;

  // Counter reload value: the issue cycle itself is the first flush cycle.
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  state_e            state_q,     state_d;
  logic              pend_vld_q,  pend_vld_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [2:0]        flush_cnt_q, flush_cnt_d;
  logic              halted_q,    halted_d;
  logic              pc_reset_q,  pc_reset_d;
  // Low for the first cycle after reset so outputs stay quiet while the
  // surrounding pipeline comes out of reset.
  logic              out_en_q,    out_en_d;

  logic              out_ok;
  logic              active;
  logic              req;
  logic [ADDR_W-1:0] req_addr;
  logic              can_issue;
  logic              issue;
  logic [ADDR_W-1:0] issue_addr;

  // Redirect selection and issue decision for the current cycle.
  always_comb begin
    out_ok     = rst_ni & out_en_q;
    // A debugger reset cycle behaves like a reset cycle: nothing issues.
    active     = out_ok & ~jtag_reset_i;
    req        = int_jump_i | ex_jump_i;
    // Interrupt/trap target always wins over an EX branch in the same cycle.
    req_addr   = int_jump_i ? int_jump_addr_i : ex_jump_addr_i;
    can_issue  = active & (state_q != ST_HALTED) & ~bus_hold_i;
    issue      = can_issue & (pend_vld_q | req);
    // A parked redirect is older than anything arriving now, so it goes first.
    issue_addr = pend_vld_q ? pend_addr_q : req_addr;
  end

  // Next-state for the pending slot, flush counter, FSM and registered outputs.
  always_comb begin
    state_d     = state_q;
    pend_vld_d  = pend_vld_q;
    pend_addr_d = pend_addr_q;
    flush_cnt_d = flush_cnt_q;
    halted_d    = halted_q;
    pc_reset_d  = jtag_reset_i;
    out_en_d    = 1'b1;

    if (active) begin
      if (can_issue) begin
        // Pending slot drains this cycle. Only an interrupt arriving alongside
        // survives (re-parked); an EX redirect here is from a squashed path.
        if (pend_vld_q && int_jump_i) begin
          pend_vld_d  = 1'b1;
          pend_addr_d = int_jump_addr_i;
        end else begin
          pend_vld_d  = 1'b0;
        end
      end else begin
        // Fetch blocked or core halted: park the redirect. Interrupts replace
        // whatever is parked; EX only fills an empty slot.
        if (int_jump_i) begin
          pend_vld_d  = 1'b1;
          pend_addr_d = int_jump_addr_i;
        end else if (ex_jump_i && !pend_vld_q) begin
          pend_vld_d  = 1'b1;
          pend_addr_d = ex_jump_addr_i;
        end
      end

      // Every issue restarts the flush window; otherwise count down to zero.
      if (issue) begin
        flush_cnt_d = FLUSH_LOAD;
      end else if (flush_cnt_q != 3'd0) begin
        flush_cnt_d = flush_cnt_q - 3'd1;
      end

      case (state_q)
        ST_RUN: begin
          if (jtag_halt_i) begin
            state_d = ST_HALT_WAIT;
          end
        end
        ST_HALT_WAIT: begin
          // Halt only once the pipeline is quiet: no multi-cycle op, no parked
          // redirect and no flush still in flight after this cycle.
          if (!jtag_halt_i) begin
            state_d = ST_RUN;
          end else if (!ex_hold_i && !pend_vld_d && (flush_cnt_d == 3'd0)) begin
            state_d = ST_HALTED;
          end
        end
        ST_HALTED: begin
          if (!jtag_halt_i) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end

    // Debugger reset discards everything in flight, like a core reset.
    if (jtag_reset_i) begin
      state_d     = ST_RUN;
      pend_vld_d  = 1'b0;
      flush_cnt_d = 3'd0;
    end

    halted_d = (state_d == ST_HALTED);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_RUN;
      pend_vld_q  <= 1'b0;
      pend_addr_q <= '0;
      flush_cnt_q <= 3'd0;
      halted_q    <= 1'b0;
      pc_reset_q  <= 1'b0;
      out_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_vld_q  <= pend_vld_d;
      pend_addr_q <= pend_addr_d;
      flush_cnt_q <= flush_cnt_d;
      halted_q    <= halted_d;
      pc_reset_q  <= pc_reset_d;
      out_en_q    <= out_en_d;
    end
  end

  // Output drive; everything is forced low during and just after reset.
  always_comb begin
    jump_flag_o = issue;
    jump_addr_o = issue ? issue_addr : '0;
    flush_o     = issue | (out_ok & (flush_cnt_q != 3'd0));
    pc_reset_o  = out_ok & pc_reset_q;
    halted_o    = out_ok & halted_q;
    hold_flag_o = 2'd0;
    if (out_ok) begin
      // pc_reg gives jump priority over hold, so hold never masks an issue.
      if (ex_hold_i || (state_q == ST_HALTED)) begin
        hold_flag_o = 2'd3;
      end else if (bus_hold_i) begin
        hold_flag_o = 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_pc_flow_ctrl.sv
module tb_pc_flow_ctrl;

  logic        clk;
  logic        rst_ni;
  logic        ex_jump_i;
  logic [31:0] ex_jump_addr_i;
  logic        int_jump_i;
  logic [31:0] int_jump_addr_i;
  logic        ex_hold_i;
  logic        bus_hold_i;
  logic        jtag_halt_i;
  logic        jtag_reset_i;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic [1:0]  hold_flag_o;
  logic        flush_o;
  logic        pc_reset_o;
  logic        halted_o;

  int n_checks = 0;
  int n_fail   = 0;

  pc_flow_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(2)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .ex_jump_i      (ex_jump_i),
    .ex_jump_addr_i (ex_jump_addr_i),
    .int_jump_i     (int_jump_i),
    .int_jump_addr_i(int_jump_addr_i),
    .ex_hold_i      (ex_hold_i),
    .bus_hold_i     (bus_hold_i),
    .jtag_halt_i    (jtag_halt_i),
    .jtag_reset_i   (jtag_reset_i),
    .jump_flag_o    (jump_flag_o),
    .jump_addr_o    (jump_addr_o),
    .hold_flag_o    (hold_flag_o),
    .flush_o        (flush_o),
    .pc_reset_o     (pc_reset_o),
    .halted_o       (halted_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record = inputs held for one clock cycle + outputs expected in that cycle.
  typedef struct {
    logic        rn;
    logic        exj;
    logic [31:0] exa;
    logic        ij;
    logic [31:0] ia;
    logic        exh;
    logic        bh;
    logic        hlt;
    logic        jr;
    logic        ejf;
    logic [31:0] eja;
    logic [1:0]  ehf;
    logic        efl;
    logic        epr;
    logic        eht;
  } vec_t;

  function automatic vec_t mk(input logic rn, input logic exj, input logic [31:0] exa,
                              input logic ij, input logic [31:0] ia, input logic exh,
                              input logic bh, input logic hlt, input logic jr,
                              input logic ejf, input logic [31:0] eja, input logic [1:0] ehf,
                              input logic efl, input logic epr, input logic eht);
    vec_t v;
    v.rn = rn; v.exj = exj; v.exa = exa; v.ij = ij; v.ia = ia; v.exh = exh;
    v.bh = bh; v.hlt = hlt; v.jr = jr;
    v.ejf = ejf; v.eja = eja; v.ehf = ehf; v.efl = efl; v.epr = epr; v.eht = eht;
    return v;
  endfunction

  // Idle cycle in run mode with expected jump/flush.
  function automatic vec_t idle(input logic efl);
    return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 2'd0, efl, 0, 0);
  endfunction

  // Drive a record just after the rising edge, check at the falling edge,
  // then move to just after the next rising edge.
  task automatic run(input string name, input vec_t v);
    logic [37:0] act;
    logic [37:0] exp_v;
    rst_ni          = v.rn;
    ex_jump_i       = v.exj;
    ex_jump_addr_i  = v.exa;
    int_jump_i      = v.ij;
    int_jump_addr_i = v.ia;
    ex_hold_i       = v.exh;
    bus_hold_i      = v.bh;
    jtag_halt_i     = v.hlt;
    jtag_reset_i    = v.jr;
    @(negedge clk);
    act   = {jump_flag_o, jump_addr_o, hold_flag_o, flush_o, pc_reset_o, halted_o};
    exp_v = {v.ejf, v.eja, v.ehf, v.efl, v.epr, v.eht};
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got jf=%0b ja=%h hf=%0d fl=%0b pr=%0b ht=%0b, expected jf=%0b ja=%h hf=%0d fl=%0b pr=%0b ht=%0b",
               name, jump_flag_o, jump_addr_o, hold_flag_o, flush_o, pc_reset_o, halted_o,
               v.ejf, v.eja, v.ehf, v.efl, v.epr, v.eht);
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    rst_ni = 1'b0; ex_jump_i = 1'b0; ex_jump_addr_i = '0; int_jump_i = 1'b0;
    int_jump_addr_i = '0; ex_hold_i = 1'b0; bus_hold_i = 1'b0;
    jtag_halt_i = 1'b0; jtag_reset_i = 1'b0;

    //              rn exj exa           ij ia            exh bh hlt jr  ejf eja           ehf  efl pr ht
    // Reset with every input high: all outputs low.
    tbl.push_back(mk(0, 1, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 1, 1, 1, 1,  0, 32'h0,     2'd0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 1, 1, 1, 1,  0, 32'h0,     2'd0, 0, 0, 0));
    // First cycle after release, then idle run.
    tbl.push_back(idle(0));
    tbl.push_back(idle(0));
    // Direct EX jump, zero latency, flush for 2 cycles.
    tbl.push_back(mk(1, 1, 32'h100,       0, 32'h0,         0, 0, 0, 0,  1, 32'h100,   2'd0, 1, 0, 0));
    tbl.push_back(idle(1));
    tbl.push_back(idle(0));
    // Interrupt beats EX in the same cycle, single issue.
    tbl.push_back(mk(1, 1, 32'h100,       1, 32'h8,         0, 0, 0, 0,  1, 32'h8,     2'd0, 1, 0, 0));
    tbl.push_back(idle(1));
    tbl.push_back(idle(0));
    // EX jump parked under bus hold for 3 cycles, issues when hold drops.
    tbl.push_back(mk(1, 1, 32'h200,       0, 32'h0,         0, 1, 0, 0,  0, 32'h0,     2'd1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 32'h0,         0, 32'h0,         0, 1, 0, 0,  0, 32'h0,     2'd1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 32'h0,         0, 32'h0,         0, 1, 0, 0,  0, 32'h0,     2'd1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 32'h0,         0, 32'h0,         0, 0, 0, 0,  1, 32'h200,   2'd0, 1, 0, 0));
    tbl.push_back(idle(1));
    tbl.push_back(idle(0));
    // New EX redirect in the hold-falling cycle: parked one wins, new one dropped.
    tbl.push_back(mk(1, 1, 32'h300,       0, 32'h0,         0, 1, 0, 0,  0, 32'h0,     2'd1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 32'h400,       0, 32'h0,         0, 0, 0, 0,  1, 32'h300,   2'd0, 1, 0, 0));
    tbl.push_back(idle(1));
    tbl.push_back(idle(0));
    // Interrupt overwrites parked EX; later EX ignored while parked.
    tbl.push_back(mk(1, 1, 32'h500,       0, 32'h0,         0, 1, 0, 0,  0, 32'h0,     2'd1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 32'h0,         1, 32'h600,       0, 1, 0, 0,  0, 32'h0,     2'd1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 32'h700,       0, 32'h0,         0, 1, 0, 0,  0, 32'h0,     2'd1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 32'h0,         0, 32'h0,         0, 0, 0, 0,  1, 32'h600,   2'd0, 1, 0, 0));
    tbl.push_back(idle(1));
    tbl.push_back(idle(0));
    // Interrupt arriving while the parked redirect issues is re-parked and issues next.
    tbl.push_back(mk(1, 1, 32'h800,       0, 32'h0,         0, 1, 0, 0,  0, 32'h0,     2'd1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 32'h0,         1, 32'h900,       0, 0, 0, 0,  1, 32'h800,   2'd0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 32'h0,         0, 32'h0,         0, 0, 0, 0,  1, 32'h900,   2'd0, 1, 0, 0));
    tbl.push_back(idle(1));
    tbl.push_back(idle(0));
    // Back-to-back jumps reload the flush window.
    tbl.push_back(mk(1, 1, 32'hA00,       0, 32'h0,         0, 0, 0, 0,  1, 32'hA00,   2'd0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 32'hA04,       0, 32'h0,         0, 0, 0, 0,  1, 32'hA04,   2'd0, 1, 0, 0));
    tbl.push_back(idle(1));
    tbl.push_back(idle(0));
    // EX hold dominates bus hold; a jump still issues under EX hold.
    tbl.push_back(mk(1, 0, 32'h0,         0, 32'h0,         1, 1, 0, 0,  0, 32'h0,     2'd3, 0, 0, 0));
    tbl.push_back(idle(0));
    tbl.push_back(mk(1, 1, 32'hB00,       0, 32'h0,         1, 0, 0, 0,  1, 32'hB00,   2'd3, 1, 0, 0));
    tbl.push_back(idle(1));
    tbl.push_back(idle(0));

    @(posedge clk);
    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      run($sformatf("vec%0d", i), tbl[i]);
    end

    // Halt requested during a 4-cycle EX hold; halted_o rises two cycles after
    // the last held cycle, a redirect is parked while halted and issues on release.
    for (int i = 0; i < 4; i++) begin
      run($sformatf("halt_wait%0d", i), mk(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 32'h0, 2'd3, 0, 0, 0));
    end
    run("halt_exhold_fell",  mk(1, 0, 0,        0, 0, 0, 0, 1, 0, 0, 32'h0,   2'd0, 0, 0, 0));
    run("halted_first",      mk(1, 0, 0,        0, 0, 0, 0, 1, 0, 0, 32'h0,   2'd3, 0, 0, 1));
    run("halted_park",       mk(1, 1, 32'hC00,  0, 0, 0, 0, 1, 0, 0, 32'h0,   2'd3, 0, 0, 1));
    run("halt_release",      mk(1, 0, 0,        0, 0, 0, 0, 0, 0, 0, 32'h0,   2'd3, 0, 0, 1));
    run("run_after_halt",    mk(1, 0, 0,        0, 0, 0, 0, 0, 0, 1, 32'hC00, 2'd0, 1, 0, 0));
    run("run_after_halt_fl", idle(1));
    run("run_after_halt_id", idle(0));

    // Debugger reset while a redirect is parked: pc_reset_o next cycle, parked redirect lost.
    run("jrst_park",   mk(1, 1, 32'hD00, 0, 0, 0, 1, 0, 0, 0, 32'h0, 2'd1, 0, 0, 0));
    run("jrst_assert", mk(1, 0, 0,       0, 0, 0, 1, 0, 1, 0, 32'h0, 2'd1, 0, 0, 0));
    run("jrst_pcrst",  mk(1, 0, 0,       0, 0, 0, 0, 0, 0, 0, 32'h0, 2'd0, 0, 1, 0));
    run("jrst_after0", idle(0));
    run("jrst_after1", idle(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
